// File: rtl/switch_debouncer_pkg.sv
// Shared types and defaults for the switch debouncer.
package swdb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } swdb_state_e;

  localparam int SWDB_SYNC_STAGES_DEF  = 2;
  localparam int SWDB_DEBOUNCE_SIM_DEF = 16;
  localparam int BOUNCE_CNT_W          = 8;

endpackage

// File: rtl/switch_debouncer_sync_chain.sv
// Plain flop chain synchroniser for asynchronous pins; no logic between stages.
module sync_chain #(
  parameter int WIDTH       = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;

  // shift the raw pins through the chain; stage 0 is the metastability catcher
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/switch_debouncer.sv
// Switch debouncer: synchronises raw board switches and commits a value only
// after DEBOUNCE_CYCLES identical samples, emitting a one-cycle valid pulse.
// Optional macro SWDB_REPORT_ON_RESET_EN: report the first qualified value
// after reset even if it equals the reset value.
module switch_debouncer
  import swdb_pkg::*;
#(
  parameter int WIDTH           = 2,
  parameter int SYNC_STAGES     = SWDB_SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = SWDB_DEBOUNCE_SIM_DEF,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WIDTH-1:0]        swRaw,
  output logic [WIDTH-1:0]        dataOut,
  output logic                    outValid,
  output logic                    busy,
  output logic [BOUNCE_CNT_W-1:0] bounceCnt
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0]        syncd;
  swdb_state_e             state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]        cand_q, cand_d;
  logic [WIDTH-1:0]        data_q, data_d;
  logic                    valid_q, valid_d;
  logic [BOUNCE_CNT_W-1:0] bounce_q, bounce_d;
  logic                    first_q;
  logic                    differs;

  sync_chain #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (swRaw),
    .q_o (syncd)
  );

`ifdef SWDB_REPORT_ON_RESET_EN
  logic first_d;

  // first flag: set by reset, dropped at the first commit
  always_ff @(posedge clk) begin
    if (rst) first_q <= 1'b1;
    else     first_q <= first_d;
  end
`else
  assign first_q = 1'b0;
`endif

  // While first is set every sample counts as a change, so the power-up
  // position (even 0) is qualified and reported once. The same notion is used
  // in COUNT so a return to the reset value restarts qualification instead of
  // aborting.
  assign differs = (syncd != data_q) | first_q;

  // state, counters and outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      cand_q   <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      bounce_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cand_q   <= cand_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      bounce_q <= bounce_d;
    end
  end

  // qualification FSM: a candidate must hold for DEBOUNCE_CYCLES samples
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cand_d   = cand_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    bounce_d = bounce_q;
`ifdef SWDB_REPORT_ON_RESET_EN
    first_d  = first_q;
`endif
    case (state_q)
      IDLE: begin
        if (differs) begin
          cand_d  = syncd;
          cnt_d   = CNT_W'(1);
          state_d = COUNT;
        end
      end
      COUNT: begin
        if (syncd == cand_q) begin
          if (cnt_q == CNT_LAST) begin
            data_d  = cand_q;
            valid_d = 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
`ifdef SWDB_REPORT_ON_RESET_EN
            first_d = 1'b0;
`endif
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          // any departure from the candidate is an aborted qualification
          if (bounce_q != '1) bounce_d = bounce_q + BOUNCE_CNT_W'(1);
          if (!differs) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cand_d = syncd;
            cnt_d  = CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign dataOut   = data_q;
  assign outValid  = valid_q;
  assign busy      = (state_q == COUNT);
  assign bounceCnt = bounce_q;

endmodule

// File: tb/tb_switch_debouncer.sv
// Randomised + directed bench for switch_debouncer with a run-length model.
module tb_switch_debouncer;
  localparam int W  = 2;
  localparam int SS = 2;
  localparam int DC = 4;
`ifdef SWDB_REPORT_ON_RESET_EN
  localparam bit FIRST_EN = 1'b1;
`else
  localparam bit FIRST_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] swRaw = '0;
  logic [W-1:0] dataOut;
  logic         outValid;
  logic         busy;
  logic [7:0]   bounceCnt;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  switch_debouncer #(
    .WIDTH           (W),
    .SYNC_STAGES     (SS),
    .DEBOUNCE_CYCLES (DC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .swRaw     (swRaw),
    .dataOut   (dataOut),
    .outValid  (outValid),
    .busy      (busy),
    .bounceCnt (bounceCnt)
  );

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Model: syncd is swRaw delayed SS samples. A value commits when it has been
  // seen for DC samples in a row and was a change when its run began. A run
  // that was a change but ended early counts as one bounce.
  logic [W-1:0] m_pipe[$];
  logic [W-1:0] m_run_val = '0;
  logic [W-1:0] m_commit = '0;
  int           m_run_len = 0;
  bit           m_cand = 1'b0;
  bit           m_first = 1'b0;
  bit           m_valid = 1'b0;
  int           m_bounce = 0;

  always @(posedge clk) begin
    logic [W-1:0] s;
    if (rst) begin
      m_pipe.delete();
      for (int i = 0; i < SS; i++) m_pipe.push_back('0);
      m_run_len = 0;
      m_cand    = 1'b0;
      m_commit  = '0;
      m_valid   = 1'b0;
      m_bounce  = 0;
      m_first   = FIRST_EN;
    end else begin
      s = m_pipe.pop_front();
      m_pipe.push_back(swRaw);
      m_valid = 1'b0;
      if (m_run_len > 0 && s == m_run_val) begin
        m_run_len++;
      end else begin
        if (m_cand) m_bounce = (m_bounce < 255) ? m_bounce + 1 : 255;
        m_run_val = s;
        m_run_len = 1;
        m_cand    = (s != m_commit) || m_first;
      end
      if (m_cand && m_run_len == DC) begin
        m_commit = m_run_val;
        m_valid  = 1'b1;
        m_cand   = 1'b0;
        m_first  = 1'b0;
      end
    end
  end

  // per-cycle compare against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("dataOut",   32'(dataOut),   32'(m_commit));
      check("outValid",  32'(outValid),  32'(m_valid));
      check("busy",      32'(busy),      32'(m_cand));
      check("bounceCnt", 32'(bounceCnt), 32'(m_bounce));
    end
  end

  // pulse log for the directed expectations
  int           npulse = 0;
  logic [W-1:0] pv[$];
  always @(negedge clk) begin
    if (chk_en && outValid === 1'b1) begin
      npulse++;
      pv.push_back(dataOut);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic reset_to0();
    swRaw = '0;
    rst   = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(10);
  endtask

  initial begin
    int p0;
    logic [W-1:0] exp_seq [4];
    exp_seq[0] = 2'b01; exp_seq[1] = 2'b10; exp_seq[2] = 2'b11; exp_seq[3] = 2'b00;

    // reset held with switches at 11: everything stays 0
    rst   = 1'b1;
    swRaw = 2'b11;
    @(negedge clk);
    chk_en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check("rst_dataOut", 32'(dataOut), 32'h0);
      check("rst_outValid", 32'(outValid), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_bounce", 32'(bounceCnt), 32'h0);
      cyc(1);
    end
    swRaw = '0;
    rst   = 1'b0;
    cyc(10);

    // clean change 00->01: pulse only after edge SS+DC-1 = 5
    swRaw = 2'b01;
    for (int k = 0; k < 8; k++) begin
      cyc(1);
      check("clean_valid", 32'(outValid), (k == 5) ? 32'h1 : 32'h0);
      check("clean_busy", 32'(busy), (k >= 2 && k <= 4) ? 32'h1 : 32'h0);
    end
    check("clean_data", 32'(dataOut), 32'h1);

    // glitch of two samples
    reset_to0();
    p0 = npulse;
    swRaw = 2'b01; cyc(2);
    swRaw = 2'b00; cyc(10);
    check("glitch_pulses", 32'(npulse - p0), 32'h0);
    check("glitch_data", 32'(dataOut), 32'h0);
    check("glitch_bounce", 32'(bounceCnt), 32'h1);

    // bounce to a third value
    reset_to0();
    p0 = npulse;
    swRaw = 2'b01; cyc(2);
    swRaw = 2'b11; cyc(12);
    check("third_pulses", 32'(npulse - p0), 32'h1);
    check("third_data", 32'(dataOut), 32'h3);
    check("third_bounce", 32'(bounceCnt), 32'h1);

    // decoder-style sequence
    reset_to0();
    pv.delete();
    p0 = npulse;
    for (int i = 0; i < 4; i++) begin
      swRaw = exp_seq[i];
      cyc(10);
    end
    check("seq_pulses", 32'(npulse - p0), 32'h4);
    for (int i = 0; i < 4; i++)
      check("seq_value", (i < pv.size()) ? 32'(pv[i]) : 32'hdead, 32'(exp_seq[i]));

    // reset two cycles into qualifying 10
    reset_to0();
    p0 = npulse;
    swRaw = 2'b10; cyc(4);
    rst = 1'b1; swRaw = 2'b00; cyc(2);
    rst = 1'b0; cyc(10);
    check("midrst_pulses", 32'(npulse - p0), FIRST_EN ? 32'h1 : 32'h0);
    check("midrst_data", 32'(dataOut), 32'h0);
    check("midrst_bounce", 32'(bounceCnt), 32'h0);

    // bounce counter saturation
    reset_to0();
    for (int i = 0; i < 300; i++) begin
      swRaw = 2'b01; cyc(2);
      swRaw = 2'b00; cyc(2);
    end
    cyc(4);
    check("bounce_sat", 32'(bounceCnt), 32'hff);

    // random holds and occasional resets, checked by the model every cycle
    reset_to0();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        rst = 1'b1;
        cyc($urandom_range(1, 2));
        rst = 1'b0;
      end
      swRaw = W'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0) cyc($urandom_range(1, DC));
      else                           cyc($urandom_range(DC, 3 * DC));
    end
    cyc(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/switch_debouncer.md
Name: switch_debouncer

Overview:
- Upstream stage of the LED decoder on the MPFS Discovery kit fabric.
- Samples the raw, asynchronous, bouncing board switches and synchronises them into `clk`.
- Debounces the switch vector and drives the decoder's `dataIn`/`inValid` pair: a clean value plus a one-cycle valid pulse per committed change.

Parameters:
- WIDTH, 2, number of switch bits; matches the decoder's `dataIn` width.
- SYNC_STAGES, 2, flops in the synchroniser chain; legal range ≥2.
- DEBOUNCE_CYCLES, 16, consecutive identical samples required to commit; legal range ≥2. Sim default; board build overrides it (e.g. 500000 = 10 ms at 50 MHz).
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), derived width of the stability counter; not overridden.

Ports:
- clk, input, 1, fabric clock.
- rst, input, 1, synchronous reset, active-high.
- swRaw, input, WIDTH, raw switch pins; asynchronous to `clk`.
- dataOut, output, WIDTH, committed debounced value; connects to decoder `dataIn`.
- outValid, output, 1, one-cycle pulse when `dataOut` changes; connects to decoder `inValid`.
- busy, output, 1, high while a candidate value is being qualified.
- bounceCnt, output, 8, saturating count of aborted candidates (diagnostic).

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: all outputs 0; synchroniser flops 0; state IDLE; counter 0; candidate 0.
- Synchroniser: `syncd` is `swRaw` delayed by SYNC_STAGES flops. No logic between the chain flops.
- State machine (`committed` = `dataOut`):
  - IDLE:
    - `syncd` == `committed`: stay in IDLE.
    - `syncd` != `committed`: cand <= syncd, cnt <= 1, go to COUNT.
  - COUNT:
    - `syncd` == cand and cnt == DEBOUNCE_CYCLES-1: `dataOut` <= cand, `outValid` <= 1 for exactly one cycle, cnt <= 0, go to IDLE.
    - `syncd` == cand otherwise: cnt++.
    - `syncd` == `committed`: abort to IDLE, cnt <= 0, bounceCnt++ (saturates at 255), no pulse.
    - `syncd` is a third value: cand <= syncd, cnt <= 1, bounceCnt++, stay in COUNT.
- `busy` = (state == COUNT), registered.
- Latency:
  - Edge 0 is the first rising edge at which `swRaw` holds the new stable value.
  - `outValid` and the new `dataOut` are visible in the cycle after edge SYNC_STAGES+DEBOUNCE_CYCLES-1 (edge 5 for 2/4).
  - Any change lasting fewer than DEBOUNCE_CYCLES samples never reaches `dataOut`.
- `outValid` is never asserted on two consecutive cycles; the minimum spacing is DEBOUNCE_CYCLES cycles.
- Multi-bit changes are qualified as a whole vector. Bits never commit independently; staggered bounces restart qualification.
- Reset mid-COUNT: candidate is discarded, no pulse, bounceCnt cleared.
- `rst` overrides every other event in the same cycle.

Optional Feature:
- Macro: SWDB_REPORT_ON_RESET_EN.
- Defined:
  - After reset release, the first qualified `syncd` value is reported once with `outValid`, even if it equals the reset value 0.
  - This is tracked by a `first` flag, set by reset and cleared at the first commit. While `first`=1, IDLE treats `syncd` as differing from `committed`.
  - Lets the decoder learn the power-up switch position.
- Undefined: only changes relative to 0 are reported; no `first` flag is synthesised.

Decomposition:
- Package swdb_pkg holds:
  - state typedef `swdb_state_e` {IDLE, COUNT}.
  - default constants `SWDB_SYNC_STAGES_DEF`=2 and `SWDB_DEBOUNCE_SIM_DEF`=16.
  - `BOUNCE_CNT_W`=8.
- One sub-module: sync_chain (WIDTH, SYNC_STAGES), a pure flop chain with reset. It is reusable for other pin inputs.
- The FSM and counters live in switch_debouncer.

Test Plan (SYNC_STAGES=2, DEBOUNCE_CYCLES=4 unless noted):
- Reset: hold `rst`=1 for 5 cycles with `swRaw`=2'b11 -> `dataOut`=00, `outValid`=0, `busy`=0, `bounceCnt`=0 throughout.
- Clean change: `swRaw` 00->01 held at edge 0 -> `outValid`=1 only in the cycle after edge 5; `dataOut`=01 from then on; `busy` high across the qualification window.
- Glitch: `swRaw`=01 for 2 cycles, then back to 00 -> no `outValid`, `dataOut` stays 00, `bounceCnt`=1.
- Bounce to third value: 00->01 for 2 cycles, then 11 held -> no pulse for 01; single pulse with `dataOut`=11 four samples after 11 first reaches `syncd`; `bounceCnt`=1.
- Sequence 01, 10, 11, 00, each held 10 cycles -> exactly 4 `outValid` pulses with those values in order. This mirrors the decoder bench stimulus and is used as a connected test with the decoder.
- Reset mid-COUNT: assert `rst` 2 cycles into qualifying 10 -> no pulse, `dataOut`=00. With SWDB_REPORT_ON_RESET_EN, `swRaw`=00 after reset -> one pulse with `dataOut`=00 after edge 5.
